library_store_mc: RTL
=====================

// Module: library_store_mc
// PURPOSE
//  Parametrised successor of the coordinate library writer. Records a stream of (x,y) samples
//  into a shared library RAM, one record ("slot") per start..deny session, at address {slot,index}.
//  New over the previous generation: registered write strobe, per-record length report, abort
//  (discard without consuming a slot), overflow detection, and width/depth/slot-count parameters.
//  Sits between the coordinate capture front end and the library SRAM write port.
// PARAMETERS
//  COORD_W   5    width of each coordinate (x and y)
//  SLOT_N    26   number of records in the library; slot index wraps SLOT_N-1 -> 0
//  DEPTH_W   11   log2 of samples per record; a record holds 2**DEPTH_W samples
//  SLOT_W    $clog2(SLOT_N)  derived localparam, not overridable
// PORTS
//  i_clk        in   1                  clock, all logic on rising edge
//  i_rst        in   1                  reset, synchronous, active-high
//  i_start      in   1                  open a record (honoured in IDLE only)
//  i_valid      in   1                  i_x/i_y carry a sample this cycle
//  i_x          in   COORD_W            sample x
//  i_y          in   COORD_W            sample y
//  i_deny       in   1                  close and commit current record
//  i_abort      in   1                  close and discard current record
//  o_wr_en      out  1                  library RAM write strobe (registered)
//  o_addr       out  SLOT_W+DEPTH_W     write address {slot, index}
//  o_x / o_y    out  COORD_W            write data; 0 when o_wr_en=0
//  o_busy       out  1                  1 while in REC
//  o_slot       out  SLOT_W             slot currently / next to be written
//  o_len        out  DEPTH_W+1          sample count of last committed record
//  o_len_valid  out  1                  1-cycle pulse: o_len updated
//  o_overflow   out  1                  sticky: samples dropped in current record
// BEHAVIOUR
//  - Reset (i_rst=1 at edge): state IDLE, slot=0, index=0, every output 0. Reset mid-record
//    drops the record and any pending write; slot is NOT advanced.
//  - FSM: IDLE --i_start--> REC; REC --i_abort--> IDLE; REC --i_deny (no abort)--> IDLE with commit.
//    i_start while in REC is ignored. i_deny/i_abort in IDLE ignored.
//  - Accept in REC when i_valid & !i_deny & !i_abort & index<2**DEPTH_W: next cycle o_wr_en=1,
//    o_addr={slot,index[DEPTH_W-1:0]}, o_x/o_y = sampled values; index += 1. Latency 1 cycle.
//  - i_valid coincident with i_deny or i_abort: sample discarded (close wins).
//  - i_abort & i_deny same cycle: abort wins, no commit.
//  - index is DEPTH_W+1 bits; cleared on entry to REC. At index=2**DEPTH_W further valids are
//    dropped and o_overflow sets; o_overflow clears on next i_start acceptance.
//  - Commit: next cycle o_len=index (0..2**DEPTH_W), o_len_valid=1 for one cycle, slot advances,
//    SLOT_N-1 -> 0. Abort: slot and o_len unchanged, no pulse.
//  - o_slot reflects the registered slot; changes the cycle after commit.
//  - o_busy=1 exactly while state=REC (registered).
//  - i_start in the same cycle as o_len_valid (state IDLE) is accepted; next record uses new slot.
// STRUCTURE
//  - Package library_pkg: state enum {IDLE,REC}, default COORD_W/SLOT_N/DEPTH_W localparams,
//    coordinate struct type {x,y} parametrised via localparam widths.
//  - One sub-module: wrap_counter #(MAX) (enable, clear, count, wrap) instantiated for the slot
//    index; sample index is a plain saturating counter in this module.
// TESTING  (defaults COORD_W=5, SLOT_N=26, DEPTH_W=11)
//  1 reset, start, 3 valids (x,y)=(1,2),(3,4),(5,6), deny -> writes at addr 0,1,2 one cycle
//    after each valid; o_len=3 pulse; o_slot=1.
//  2 26 records of 1 sample each -> 26th write at addr {25,0}; after commit o_slot=0; 27th
//    record writes addr 0.
//  3 start, 2 valids, abort -> no o_len_valid, o_slot unchanged; next record reuses same slot
//    from index 0.
//  4 start, 2050 valids, deny -> 2048 writes (last addr {0,2047}), o_overflow=1, o_len=2048.
//  5 i_valid with i_deny same cycle -> no write for that sample; i_abort with i_deny -> abort.
//  6 i_rst asserted mid-record after 5 samples -> all outputs 0 next cycle, o_slot=0, no pulse.

Source files
------------

// File: rtl/library_pkg.sv
// Shared types and default geometry for the coordinate library writer.
package library_pkg;

  localparam int COORD_W_DEF = 5;
  localparam int SLOT_N_DEF  = 26;
  localparam int DEPTH_W_DEF = 11;

  typedef enum logic {
    IDLE = 1'b0,
    REC  = 1'b1
  } state_t;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } coord_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter; wrap flags the terminal value so the owner can clear it.
module wrap_counter #(
  parameter int MAX = 26,
  parameter int W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign wrap = (count == W'(MAX - 1));

endmodule

// File: rtl/library_store_mc.sv
// Records start..deny sessions of (x,y) samples into the library RAM,
// one slot per committed record, addressed {slot,index}.
module library_store_mc
  import library_pkg::*;
#(
  parameter int  COORD_W = COORD_W_DEF,
  parameter int  SLOT_N  = SLOT_N_DEF,
  parameter int  DEPTH_W = DEPTH_W_DEF,
  localparam int SLOT_W  = $clog2(SLOT_N)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_valid,
  input  logic [COORD_W-1:0]        i_x,
  input  logic [COORD_W-1:0]        i_y,
  input  logic                      i_deny,
  input  logic                      i_abort,
  output logic                      o_wr_en,
  output logic [SLOT_W+DEPTH_W-1:0] o_addr,
  output logic [COORD_W-1:0]        o_x,
  output logic [COORD_W-1:0]        o_y,
  output logic                      o_busy,
  output logic [SLOT_W-1:0]         o_slot,
  output logic [DEPTH_W:0]          o_len,
  output logic                      o_len_valid,
  output logic                      o_overflow
);

  state_t              state;
  logic [DEPTH_W:0]    index;
  logic [SLOT_W-1:0]   slot;
  logic                slot_adv;
  logic                slot_last;
  logic                full;

  // index saturates at 2**DEPTH_W, so its top bit alone marks a full record
  assign full     = index[DEPTH_W];
  assign slot_adv = (state == REC) && i_deny && !i_abort;

  wrap_counter #(
    .MAX (SLOT_N),
    .W   (SLOT_W)
  ) u_slot (
    .clk    (i_clk),
    .rst    (i_rst),
    .enable (slot_adv),
    .clear  (slot_adv && slot_last),
    .count  (slot),
    .wrap   (slot_last)
  );

  assign o_slot = slot;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      index       <= '0;
      o_wr_en     <= 1'b0;
      o_addr      <= '0;
      o_x         <= '0;
      o_y         <= '0;
      o_busy      <= 1'b0;
      o_len       <= '0;
      o_len_valid <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_wr_en     <= 1'b0;
      o_addr      <= '0;
      o_x         <= '0;
      o_y         <= '0;
      o_len_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state      <= REC;
            o_busy     <= 1'b1;
            index      <= '0;
            o_overflow <= 1'b0;
          end
        end
        REC: begin
          if (i_abort) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (i_deny) begin
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_len       <= index;
            o_len_valid <= 1'b1;
          end else if (i_valid) begin
            if (!full) begin
              o_wr_en <= 1'b1;
              o_addr  <= {slot, index[DEPTH_W-1:0]};
              o_x     <= i_x;
              o_y     <= i_y;
              index   <= index + 1'b1;
            end else begin
              o_overflow <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
